// File: rtl/pi_pkg.sv
// Shared widths and the channel-index width helper for the multi-channel PI pipeline.
package pi_pkg;

    localparam int DEF_CHANNELS     = 4;
    localparam int DEF_INPUT_WIDTH  = 18;
    localparam int DEF_OUTPUT_WIDTH = 32;

    // A single channel still needs a one-bit select port.
    function automatic int cw_of(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/pi_sat.sv
// Signed clamp of value_i into [min_i, max_i]; sat_o flags that the value was limited.
module pi_sat #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] value_i,
    input  logic signed [WIDTH-1:0] min_i,
    input  logic signed [WIDTH-1:0] max_i,
    output logic signed [WIDTH-1:0] value_o,
    output logic                    sat_o
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        value_o = value_i;
        sat_o   = 1'b0;
        if (value_i > max_i) begin
            value_o = max_i;
            sat_o   = 1'b1;
        end else if (value_i < min_i) begin
            value_o = min_i;
            sat_o   = 1'b1;
        end
    end

endmodule

// File: rtl/pi_mc_pipeline.sv
// Four-stage multi-channel PI controller: error, clamped integral update, gain products,
// shifted and clamped result. One sample per cycle, per-channel state in register arrays.
module pi_mc_pipeline
    import pi_pkg::*;
#(
    parameter int  CHANNELS     = DEF_CHANNELS,
    parameter int  INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int  OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
    parameter int  SHIFT        = 0,
    localparam int CW           = cw_of(CHANNELS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [CW-1:0]                  in_channel,
    input  logic signed [INPUT_WIDTH-1:0]  setpoint,
    input  logic signed [INPUT_WIDTH-1:0]  actual,
    input  logic                           cfg_we,
    input  logic [CW-1:0]                  cfg_channel,
    input  logic signed [INPUT_WIDTH-1:0]  cfg_kp,
    input  logic signed [INPUT_WIDTH-1:0]  cfg_ki,
    input  logic                           clr_valid,
    input  logic [CW-1:0]                  clr_channel,
    input  logic [OUTPUT_WIDTH-1:0]        int_limit,
    input  logic signed [OUTPUT_WIDTH-1:0] out_min,
    input  logic signed [OUTPUT_WIDTH-1:0] out_max,
    output logic                           out_valid,
    output logic [CW-1:0]                  out_channel,
    output logic signed [OUTPUT_WIDTH-1:0] out_result,
    output logic signed [OUTPUT_WIDTH-1:0] out_integral,
    output logic                           out_saturated
);

    localparam int IW  = INPUT_WIDTH;
    localparam int OW  = OUTPUT_WIDTH;
    localparam int OW1 = OW + 1;
    localparam int PW  = OW + IW;
    localparam int SW  = PW + 1;
    localparam logic [31:0] CH_LIMIT = 32'(CHANNELS);

    logic signed [OW-1:0] integ_q [CHANNELS];
    logic signed [IW-1:0] kp_q    [CHANNELS];
    logic signed [IW-1:0] ki_q    [CHANNELS];

    // S0: range check and error
    logic                 s0_accept;
    logic signed [OW-1:0] s0_err_d;
    logic                 s0_valid_q;
    logic [CW-1:0]        s0_ch_q;
    logic signed [OW-1:0] s0_err_q;

    assign s0_accept = in_valid && (32'(in_channel) < CH_LIMIT);
    assign s0_err_d  = OW'(actual) - OW'(setpoint);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
            s0_ch_q    <= '0;
            s0_err_q   <= '0;
        end else begin
            s0_valid_q <= s0_accept;
            if (s0_accept) begin
                s0_ch_q  <= in_channel;
                s0_err_q <= s0_err_d;
            end
        end
    end

    // S1: read-modify-write of the integral, clamped symmetrically to int_limit
    logic signed [OW1-1:0] s1_sum;
    logic signed [OW1-1:0] s1_lim_hi;
    logic signed [OW1-1:0] s1_lim_lo;
    logic signed [OW1-1:0] s1_clamped;
    logic                  s1_clamp_flag;
    logic signed [OW-1:0]  s1_int_d;
    logic                  s1_valid_q;
    logic [CW-1:0]         s1_ch_q;
    logic signed [OW-1:0]  s1_err_q;
    logic signed [OW-1:0]  s1_int_q;

    assign s1_sum    = OW1'(integ_q[s0_ch_q]) + OW1'(s0_err_q);
    assign s1_lim_hi = $signed({1'b0, int_limit});
    assign s1_lim_lo = -s1_lim_hi;
    assign s1_int_d  = s1_clamped[OW-1:0];

    pi_sat #(.WIDTH(OW1)) u_sat_int (
        .value_i (s1_sum),
        .min_i   (s1_lim_lo),
        .max_i   (s1_lim_hi),
        .value_o (s1_clamped),
        .sat_o   (s1_clamp_flag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the per-channel arrays are small register files, so they take the async reset too.
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                integ_q[i] <= '0;
                kp_q[i]    <= '0;
                ki_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                // A coincident clear beats the S1 write-back; the in-flight sample keeps its value.
                if (clr_valid && clr_channel == CW'(i)) begin
                    integ_q[i] <= '0;
                end else if (s0_valid_q && s0_ch_q == CW'(i)) begin
                    integ_q[i] <= s1_int_d;
                end
                if (cfg_we && cfg_channel == CW'(i)) begin
                    kp_q[i] <= cfg_kp;
                    ki_q[i] <= cfg_ki;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_ch_q    <= '0;
            s1_err_q   <= '0;
            s1_int_q   <= '0;
        end else begin
            s1_valid_q <= s0_valid_q;
            if (s0_valid_q) begin
                s1_ch_q  <= s0_ch_q;
                s1_err_q <= s0_err_q;
                s1_int_q <= s1_int_d;
            end
        end
    end

    // S2: full-precision products with the gains current in this cycle
    logic signed [PW-1:0] s2_p_d;
    logic signed [PW-1:0] s2_i_d;
    logic                 s2_valid_q;
    logic [CW-1:0]        s2_ch_q;
    logic signed [PW-1:0] s2_p_q;
    logic signed [PW-1:0] s2_i_q;
    logic signed [OW-1:0] s2_int_q;

    assign s2_p_d = PW'(s1_err_q) * PW'(kp_q[s1_ch_q]);
    assign s2_i_d = PW'(s1_int_q) * PW'(ki_q[s1_ch_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_ch_q    <= '0;
            s2_p_q     <= '0;
            s2_i_q     <= '0;
            s2_int_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_ch_q  <= s1_ch_q;
                s2_p_q   <= s2_p_d;
                s2_i_q   <= s2_i_d;
                s2_int_q <= s1_int_q;
            end
        end
    end

    // S3: scale, clamp to the output window, register outputs
    logic signed [SW-1:0] s3_sum;
    logic signed [SW-1:0] s3_shifted;
    logic signed [SW-1:0] s3_clamped;
    logic                 s3_sat;

    assign s3_sum     = SW'(s2_p_q) + SW'(s2_i_q);
    assign s3_shifted = s3_sum >>> SHIFT;

    pi_sat #(.WIDTH(SW)) u_sat_out (
        .value_i (s3_shifted),
        .min_i   (SW'(out_min)),
        .max_i   (SW'(out_max)),
        .value_o (s3_clamped),
        .sat_o   (s3_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_channel   <= '0;
            out_result    <= '0;
            out_integral  <= '0;
            out_saturated <= 1'b0;
        end else begin
            out_valid <= s2_valid_q;
            if (s2_valid_q) begin
                out_channel   <= s2_ch_q;
                out_result    <= s3_clamped[OW-1:0];
                out_integral  <= s2_int_q;
                out_saturated <= s3_sat;
            end
        end
    end

    // The clamps bound these bits to pure sign extension, so they carry no information.
    logic unused_ok;
    assign unused_ok = ^{s1_clamp_flag, s1_clamped[OW], s3_clamped[SW-1:OW]};

endmodule

// File: tb/tb_pi_mc_pipeline.sv
// Scoreboard bench for pi_mc_pipeline: directed samples push expected results, a negedge
// monitor pops and compares whenever out_valid is high.
module tb_pi_mc_pipeline;

    localparam int CH = 5;
    localparam int IW = 18;
    localparam int OW = 32;
    localparam int CW = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 in_valid = 1'b0;
    logic [CW-1:0]        in_channel = '0;
    logic signed [IW-1:0] setpoint = '0;
    logic signed [IW-1:0] actual = '0;
    logic                 cfg_we = 1'b0;
    logic [CW-1:0]        cfg_channel = '0;
    logic signed [IW-1:0] cfg_kp = '0;
    logic signed [IW-1:0] cfg_ki = '0;
    logic                 clr_valid = 1'b0;
    logic [CW-1:0]        clr_channel = '0;
    logic [OW-1:0]        int_limit = 32'd1_000_000;
    logic signed [OW-1:0] out_min = -32'sd1_000_000;
    logic signed [OW-1:0] out_max = 32'sd1_000_000;
    logic                 out_valid;
    logic [CW-1:0]        out_channel;
    logic signed [OW-1:0] out_result;
    logic signed [OW-1:0] out_integral;
    logic                 out_saturated;

    pi_mc_pipeline #(
        .CHANNELS(CH), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .SHIFT(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_channel(in_channel), .setpoint(setpoint), .actual(actual),
        .cfg_we(cfg_we), .cfg_channel(cfg_channel), .cfg_kp(cfg_kp), .cfg_ki(cfg_ki),
        .clr_valid(clr_valid), .clr_channel(clr_channel),
        .int_limit(int_limit), .out_min(out_min), .out_max(out_max),
        .out_valid(out_valid), .out_channel(out_channel), .out_result(out_result),
        .out_integral(out_integral), .out_saturated(out_saturated)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     ch;
        longint res;
        longint integ;
        bit     sat;
        int     cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every out_valid must match the oldest expected entry.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", out_valid, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_channel", out_channel, e.ch);
                check("out_result", out_result, e.res);
                check("out_integral", out_integral, e.integ);
                check("out_saturated", out_saturated, e.sat);
                check("latency", cyc - e.cyc, 4);
            end
        end
    end

    task automatic sample(input int ch, input int sp, input int act,
                          input longint res, input longint integ, input bit sat,
                          input bit expect_out);
        @(negedge clk);
        in_valid   = 1'b1;
        in_channel = CW'(ch);
        setpoint   = IW'(sp);
        actual     = IW'(act);
        if (expect_out) sb.push_back('{ch, res, integ, sat, cyc});
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(negedge clk);
    endtask

    task automatic cfg(input int ch, input int kp, input int ki);
        @(negedge clk);
        in_valid    = 1'b0;
        cfg_we      = 1'b1;
        cfg_channel = CW'(ch);
        cfg_kp      = IW'(kp);
        cfg_ki      = IW'(ki);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        // Asynchronous reset, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_integral", out_integral, 0);
        check("rst_out_saturated", out_saturated, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single sample: kp=2 ki=1, error 10 -> 20 + 10
        cfg(0, 2, 1);
        sample(0, 0, 10, 30, 10, 0, 1);
        idle();
        drain();

        // Back-to-back accumulation on one channel
        cfg(1, 0, 1);
        sample(1, 0, 5, 5, 5, 0, 1);
        sample(1, 0, 5, 10, 10, 0, 1);
        sample(1, 0, 5, 15, 15, 0, 1);
        idle();
        drain();

        // Integral and output clamps, both polarities
        cfg(4, 1, 0);
        @(negedge clk);
        int_limit = 32'd100;
        out_max   = 32'sd50;
        out_min   = -32'sd50;
        sample(4, 0, 60, 50, 60, 1, 1);
        sample(4, 0, 60, 50, 100, 1, 1);
        sample(4, 80, 0, -50, 20, 1, 1);
        sample(4, 200, 0, -50, -100, 1, 1);
        sample(4, 0, 30, 30, -70, 0, 1);
        idle();
        drain();
        int_limit = 32'd1_000_000;
        out_max   = 32'sd1_000_000;
        out_min   = -32'sd1_000_000;

        // Clear coinciding with an S1 update of the same channel
        cfg(2, 0, 1);
        sample(2, 0, 4, 4, 4, 0, 1);
        sample(2, 0, 3, 7, 7, 0, 1);
        @(negedge clk);
        in_valid    = 1'b0;
        clr_valid   = 1'b1;
        clr_channel = CW'(2);
        @(negedge clk);
        clr_valid = 1'b0;
        drain();
        sample(2, 0, 7, 7, 7, 0, 1);
        idle();
        drain();

        // Interleaved channels with different gains, plus an out-of-range channel
        cfg(3, 3, 2);
        cfg(5, 99, 99);
        sample(0, 0, 1, 13, 11, 0, 1);
        sample(3, 0, 2, 10, 2, 0, 1);
        sample(0, 1, 0, 8, 10, 0, 1);
        sample(3, 0, 4, 24, 6, 0, 1);
        sample(5, 0, 100, 0, 0, 0, 0);
        sample(3, 0, 0, 12, 6, 0, 1);
        sample(0, 0, 0, 10, 10, 0, 1);
        idle();
        drain();

        // Reset with three samples in flight
        sample(1, 0, 1, 0, 0, 0, 0);
        sample(1, 0, 1, 0, 0, 0, 0);
        sample(1, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_inflight_out_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        // Sample presented so it is captured on the first edge after release
        rst_n      = 1'b1;
        in_valid   = 1'b1;
        in_channel = CW'(0);
        setpoint   = '0;
        actual     = '0;
        sb.push_back('{0, 0, 0, 1'b0, cyc});
        for (int c = 1; c < CH; c++) sample(c, 0, 0, 0, 0, 0, 1);
        idle();

        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
